uart_tx_fifo_ctrl: RTL and testbench
====================================

# uart_tx_fifo_ctrl

Parametrised UART transmitter with an internal write FIFO. It serialises bytes from the system logic onto a single `tx` line. Baud divisor, data width, parity mode, stop-bit count and buffer depth are all configurable. Queued words go out back-to-back with no idle gap. It sits between the host-side upload logic and the board UART pin, and supersedes the fixed 8N1, single-byte transmitter.

## Interface
Parameters:
- `CLK_DIV`, 52: clock cycles per bit; legal range 2..65535.
- `DATA_BITS`, 8: data bits per frame; legal range 5..8.
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.
- `DEPTH`, 16: FIFO depth in words; a power of two, 2..256.

Ports:
- `clock_system`  in  1  system clock; sole clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `data_send`  in  DATA_BITS  word to transmit.
- `wr`  in  1  write strobe, level-sampled; one word is accepted per cycle while `wr & ~full`.
- `full`  out  1  FIFO holds DEPTH words.
- `empty`  out  1  FIFO holds 0 words.
- `busy`  out  1  a frame is on the line (START through the last STOP period).
- `overflow`  out  1  sticky; set by `wr & full`; cleared only by `rst`.
- `tx`  out  1  serial line; idles high.

## Operation
- Reset: `tx`=1, `busy`=0, `full`=0, `empty`=1, `overflow`=0; FIFO pointers, bit counter and baud counter are all zeroed.
  - Asserting `rst` mid-frame aborts the frame immediately and discards all queued words.
- Write:
  - `wr & ~full` pushes `data_send` at the clock edge.
  - `wr & full` drops the word and sets `overflow`.
  - When the FIFO is full, a push and a pop in the same cycle is not possible, because `full` blocks the push.
  - A push and a pop in the same cycle at any other occupancy leave the count unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head word into the shift register, compute parity, go to START.
  - START: `tx`=0 for CLK_DIV cycles, then go to DATA.
  - DATA: send bits LSB first, CLK_DIV cycles each, DATA_BITS bits total. Then go to PAR if PARITY≠0, otherwise STOP.
  - PAR: send one parity bit for CLK_DIV cycles, then go to STOP. Odd parity = ~^word; even parity = ^word.
  - STOP: `tx`=1 for STOP_BITS×CLK_DIV cycles. On the final cycle, if the FIFO is non-empty, pop the next word and go straight to START (no idle cycle); otherwise go to IDLE.
- The word is captured at pop time. Later changes to `data_send` or to FIFO contents do not affect the frame in flight.
- The baud counter runs 0..CLK_DIV-1 and wraps at each bit boundary. A bit boundary occurs exactly when the count reaches CLK_DIV-1. Every bit therefore lasts exactly CLK_DIV cycles, with no drift.

## Timing
- `tx` and `busy` are registered outputs.
- `full`, `empty` and `overflow` are registered and reflect the state after each clock edge.
- Latency: a word pushed at edge k into an empty FIFO with the FSM in IDLE produces:
  - pop at edge k+1;
  - `tx` falling and `busy` rising after edge k+1.
- Frame length: CLK_DIV × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop cycle, and `busy` stays high between the two frames.
- `empty` rises on the edge that pops the last word, not when its frame ends.

## Structure
- Shared package `uart_pkg`:
  - parity mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - the FSM state encoding type;
  - `clog2` helper function.
- Sub-module `uart_sync_fifo`:
  - parameters WIDTH, DEPTH;
  - push, pop, dout, full, empty;
  - read/write pointers one bit wider than the address for full/empty detection;
  - async active-high reset.
- The top level holds the FSM, baud counter, bit counter, shift register and overflow flag.

## Test plan
- Defaults (CLK_DIV=52, 8N1): one write of 0x55 → `tx` low after edge k+1. Then bits 1,0,1,0,1,0,1,0, then high. Every bit is exactly 52 cycles; `busy` is high for 520 cycles.
- CLK_DIV=4, PARITY=2 (even), STOP_BITS=2: write 0x07 → frame 0,1,1,1,0,0,0,0,0, then parity 1, then 1,1. Frame length is 48 cycles.
- CLK_DIV=4, DEPTH=4: burst-write 0xA1, 0xB2, 0xC3 on consecutive cycles → three frames with no idle cycle between them. `busy` stays high for 120 cycles; `empty` rises when the third word is popped.
- DEPTH=4: with the line busy, write 6 words → `full` asserts after 4 pushes and `overflow` sets. Only the first 5 words are transmitted (1 already popped into the shifter, then 4 from the FIFO); `overflow` stays set after the line idles.
- Reset mid-frame (during DATA bit 3): `tx`=1, `busy`=0 and `empty`=1 asynchronously. After deassert, the next write transmits a clean frame.
- PARITY=1 (odd), DATA_BITS=7: write 0x00 → parity bit 1. Write 0x7F → parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and helpers for the UART transmit path.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read and wrap-bit pointers.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock_system,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clock_system) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clock_system or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Configurable UART transmitter draining a write FIFO onto the tx line,
// sending queued words back-to-back without idle gaps.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 52,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16
) (
  input  logic                 clock_system,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_send,
  input  logic                 wr,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic                 overflow,
  output logic                 tx
);

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_t          r_state;
  uart_state_t          w_next_state;
  logic [15:0]          r_baud;
  logic [15:0]          w_baud_next;
  logic [2:0]           r_bit;
  logic [2:0]           w_bit_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 r_par;
  logic                 w_par_next;
  logic                 r_tx;
  logic                 w_tx_next;
  logic                 r_busy;
  logic                 w_busy_next;
  logic                 r_overflow;
  logic                 w_tick;
  logic                 w_pop;
  logic                 w_load_par;
  logic [DATA_BITS-1:0] w_fifo_dout;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;

  uart_sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock_system(clock_system),
    .rst         (rst),
    .i_push      (wr),
    .i_din       (data_send),
    .i_pop       (w_pop),
    .o_dout      (w_fifo_dout),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign w_tick     = (r_baud == BAUD_LAST);
  assign w_load_par = (PARITY == PAR_ODD) ? ~^w_fifo_dout : ^w_fifo_dout;

  always_ff @(posedge clock_system or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // A pop happens from IDLE or on the last STOP cycle, so frames chain directly.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_START;
        end
      end
      ST_START: if (w_tick) w_next_state = ST_DATA;
      ST_DATA: begin
        if (w_tick && r_bit == DATA_LAST)
          w_next_state = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
      end
      ST_PAR: if (w_tick) w_next_state = ST_STOP;
      ST_STOP: begin
        if (w_tick && r_bit == STOP_LAST) begin
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_next_state = ST_START;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_baud_next  = (r_state == ST_IDLE || w_tick) ? 16'd0 : r_baud + 16'd1;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_par_next   = r_par;
    if (w_pop) begin
      w_shift_next = w_fifo_dout;
      w_par_next   = w_load_par;
      w_bit_next   = 3'd0;
    end else if (w_tick && r_state != w_next_state) begin
      w_bit_next = 3'd0;
    end else if (w_tick && (r_state == ST_DATA || r_state == ST_STOP)) begin
      w_bit_next = r_bit + 3'd1;
      if (r_state == ST_DATA) w_shift_next = r_shift >> 1;
    end
  end

  // Line level is derived from the upcoming state so tx and busy can be registered.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_next_state)
      ST_START: w_tx_next = 1'b0;
      ST_DATA:  w_tx_next = w_shift_next[0];
      ST_PAR:   w_tx_next = w_par_next;
      default:  w_tx_next = 1'b1;
    endcase
    w_busy_next = (w_next_state != ST_IDLE);
  end

  always_ff @(posedge clock_system or posedge rst) begin
    if (rst) begin
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_baud     <= w_baud_next;
      r_bit      <= w_bit_next;
      r_shift    <= w_shift_next;
      r_par      <= w_par_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
      r_overflow <= r_overflow | (wr & w_fifo_full);
    end
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign overflow = r_overflow;
  assign full     = w_fifo_full;
  assign empty    = w_fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Four differently configured transmitters checked every cycle against a
// frame-level model, plus hand-computed frame and timing expectations.
module tb_uart_tx_fifo_ctrl;

  logic       clk  = 1'b0;
  logic [3:0] rstV = 4'hF;
  logic [3:0] wrV  = 4'h0;
  logic [7:0] dataV [4];
  wire  [3:0] txV, busyV, fullV, emptyV, ovfV;
  int         checks   = 0;
  int         failures = 0;
  bit         checking = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo_ctrl #(.CLK_DIV(52)) dutA (
    .clock_system(clk), .rst(rstV[0]), .data_send(dataV[0]), .wr(wrV[0]),
    .full(fullV[0]), .empty(emptyV[0]), .busy(busyV[0]), .overflow(ovfV[0]), .tx(txV[0]));

  uart_tx_fifo_ctrl #(.CLK_DIV(4), .PARITY(2), .STOP_BITS(2), .DEPTH(4)) dutB (
    .clock_system(clk), .rst(rstV[1]), .data_send(dataV[1]), .wr(wrV[1]),
    .full(fullV[1]), .empty(emptyV[1]), .busy(busyV[1]), .overflow(ovfV[1]), .tx(txV[1]));

  uart_tx_fifo_ctrl #(.CLK_DIV(4), .DEPTH(4)) dutC (
    .clock_system(clk), .rst(rstV[2]), .data_send(dataV[2]), .wr(wrV[2]),
    .full(fullV[2]), .empty(emptyV[2]), .busy(busyV[2]), .overflow(ovfV[2]), .tx(txV[2]));

  uart_tx_fifo_ctrl #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1)) dutD (
    .clock_system(clk), .rst(rstV[3]), .data_send(dataV[3][6:0]), .wr(wrV[3]),
    .full(fullV[3]), .empty(emptyV[3]), .busy(busyV[3]), .overflow(ovfV[3]), .tx(txV[3]));

  function automatic int cfgDiv(input int id);
    return (id == 0) ? 52 : 4;
  endfunction
  function automatic int cfgDb(input int id);
    return (id == 3) ? 7 : 8;
  endfunction
  function automatic int cfgPar(input int id);
    return (id == 1) ? 2 : (id == 3) ? 1 : 0;
  endfunction
  function automatic int cfgStop(input int id);
    return (id == 1) ? 2 : 1;
  endfunction
  function automatic int cfgDepth(input int id);
    return (id == 1 || id == 2) ? 4 : 16;
  endfunction

  // Model: word queue plus the frame currently on the line as a bit list and elapsed time.
  int         mCount [4];
  int         mHead [4];
  int         mElapsed [4];
  int         mFrameLen [4];
  int         mFrames [4];
  bit         mActive [4];
  bit         mOvf [4];
  logic [11:0] mBits [4];
  logic [7:0] mMem [4][256];

  task automatic modelEdge(input int id);
    int nb;
    int ones;
    logic [7:0] word;
    bit wasFull;
    bit endFrame;
    bit doPush;
    if (rstV[id]) begin
      mCount[id] = 0; mHead[id] = 0; mElapsed[id] = 0;
      mActive[id] = 1'b0; mOvf[id] = 1'b0;
      return;
    end
    wasFull  = (mCount[id] == cfgDepth(id));
    doPush   = wrV[id] && !wasFull;
    if (wrV[id] && wasFull) mOvf[id] = 1'b1;
    endFrame = mActive[id] && (mElapsed[id] == mFrameLen[id] - 1);
    if ((!mActive[id] || endFrame) && mCount[id] > 0) begin
      word = mMem[id][mHead[id]] & 8'((1 << cfgDb(id)) - 1);
      mHead[id] = (mHead[id] + 1) % cfgDepth(id);
      mCount[id]--;
      mBits[id] = '1;
      mBits[id][0] = 1'b0;
      for (int j = 0; j < cfgDb(id); j++) mBits[id][1 + j] = word[j];
      nb = 1 + cfgDb(id);
      ones = $countones(word);
      if (cfgPar(id) == 1) begin mBits[id][nb] = (ones % 2 == 0); nb++; end
      else if (cfgPar(id) == 2) begin mBits[id][nb] = (ones % 2 == 1); nb++; end
      nb += cfgStop(id);
      mFrameLen[id] = nb * cfgDiv(id);
      mElapsed[id] = 0;
      mActive[id] = 1'b1;
      mFrames[id]++;
    end else if (endFrame) begin
      mActive[id] = 1'b0;
    end else if (mActive[id]) begin
      mElapsed[id]++;
    end
    if (doPush) begin
      mMem[id][(mHead[id] + mCount[id]) % cfgDepth(id)] = dataV[id];
      mCount[id]++;
    end
  endtask

  always @(posedge clk) begin
    for (int id = 0; id < 4; id++) modelEdge(id);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int id = 0; id < 4; id++) begin
        logic [4:0] expV;
        expV = {mActive[id] ? mBits[id][mElapsed[id] / cfgDiv(id)] : 1'b1,
                mActive[id], mCount[id] == cfgDepth(id), mCount[id] == 0, mOvf[id]};
        checkOutput($sformatf("cycle_dut%0d", id),
                    {27'd0, txV[id], busyV[id], fullV[id], emptyV[id], ovfV[id]},
                    {27'd0, expV});
      end
    end
  end

  task automatic applyStimulus(input int id, input logic [7:0] d);
    dataV[id] = d;
    wrV[id]   = 1'b1;
    @(negedge clk);
    #2;
    wrV[id]   = 1'b0;
  endtask

  // Starts on the negedge of frame cycle 0; samples mid-bit and measures busy width.
  task automatic watchFrame(input int id, output logic [11:0] bits, output int len);
    int c;
    int div;
    div  = cfgDiv(id);
    bits = '1;
    c    = 0;
    while (busyV[id] && c < 2000) begin
      if ((c % div) == div / 2 && (c / div) < 12) bits[c / div] = txV[id];
      @(negedge clk);
      c++;
    end
    len = c;
  endtask

  task automatic watchBusy(input int id, input int start, output int len, output int emptyAt);
    int c;
    c = start;
    emptyAt = -1;
    while (busyV[id] && c < 2000) begin
      if (emptyV[id] && emptyAt < 0) emptyAt = c;
      @(negedge clk);
      c++;
    end
    len = c;
  endtask

  initial begin
    logic [11:0] bits;
    int len;
    int emptyAt;
    int frames0;
    for (int i = 0; i < 4; i++) dataV[i] = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    rstV = 4'h0;
    for (int id = 0; id < 4; id++)
      checkOutput($sformatf("reset_state_dut%0d", id),
                  {27'd0, txV[id], busyV[id], fullV[id], emptyV[id], ovfV[id]}, 32'b10010);
    checking = 1'b1;

    // 8N1 at divisor 52: latency, bit pattern and frame width
    applyStimulus(0, 8'h55);
    checkOutput("busy_before_pop", busyV[0], 0);
    @(negedge clk);
    checkOutput("tx_start_low", txV[0], 0);
    checkOutput("busy_start_high", busyV[0], 1);
    checkOutput("model_len_8n1", mFrameLen[0], 520);
    watchFrame(0, bits, len);
    #2;
    checkOutput("frame_0x55", bits[9:0], 10'h2AA);
    checkOutput("busy_len_8n1", len, 520);

    // even parity, two stop bits
    applyStimulus(1, 8'h07);
    @(negedge clk);
    watchFrame(1, bits, len);
    #2;
    checkOutput("frame_0x07_8E2", bits, 12'hE0E);
    checkOutput("busy_len_8E2", len, 48);
    checkOutput("model_len_8E2", mFrameLen[1], 48);

    // three-word burst goes out back-to-back
    dataV[2] = 8'hA1; wrV[2] = 1'b1;
    @(negedge clk); #2; dataV[2] = 8'hB2;
    @(negedge clk); #2; dataV[2] = 8'hC3;
    @(negedge clk); #2; wrV[2] = 1'b0;
    watchBusy(2, 1, len, emptyAt);
    #2;
    checkOutput("burst_busy_len", len, 120);
    checkOutput("burst_empty_at", emptyAt, 80);

    // six writes: one lands in the shifter, four fill the FIFO, the last is dropped
    frames0 = mFrames[2];
    for (int i = 0; i < 6; i++) begin
      dataV[2] = 8'(8'h10 + i);
      wrV[2]   = 1'b1;
      @(negedge clk);
      if (i == 4) begin
        checkOutput("full_after_4_pushes", fullV[2], 1);
        checkOutput("ovf_not_yet", ovfV[2], 0);
      end
      if (i == 5) checkOutput("ovf_set", ovfV[2], 1);
      #2;
    end
    wrV[2] = 1'b0;
    watchBusy(2, 4, len, emptyAt);
    #2;
    checkOutput("ovf_busy_len", len, 200);
    checkOutput("ovf_sticky_idle", ovfV[2], 1);
    checkOutput("ovf_frames_sent", mFrames[2] - frames0, 5);

    // asynchronous reset during data bit 3 with a word still queued
    applyStimulus(2, 8'h3C);
    applyStimulus(2, 8'h99);
    repeat (17) @(negedge clk);
    #2;
    checkOutput("busy_mid_frame", busyV[2], 1);
    checkOutput("queued_mid_frame", emptyV[2], 0);
    rstV[2] = 1'b1;
    #1;
    checkOutput("rst_async_tx", txV[2], 1);
    checkOutput("rst_async_busy", busyV[2], 0);
    checkOutput("rst_async_empty", emptyV[2], 1);
    checkOutput("rst_async_ovf", ovfV[2], 0);
    @(negedge clk); #2;
    rstV[2] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("idle_after_reset", busyV[2], 0);
    applyStimulus(2, 8'hC5);
    @(negedge clk);
    watchFrame(2, bits, len);
    #2;
    checkOutput("clean_frame_0xC5", bits[9:0], 10'h38A);
    checkOutput("clean_frame_len", len, 40);

    // 7-bit odd parity
    applyStimulus(3, 8'h00);
    @(negedge clk);
    watchFrame(3, bits, len);
    #2;
    checkOutput("odd_par_0x00", bits[8], 1);
    checkOutput("frame_0x00_7O1", bits[9:0], 10'h300);
    applyStimulus(3, 8'h7F);
    @(negedge clk);
    watchFrame(3, bits, len);
    #2;
    checkOutput("odd_par_0x7F", bits[8], 0);
    checkOutput("frame_0x7F_7O1", bits[9:0], 10'h2FE);
    checkOutput("len_7O1", len, 40);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
